mul_sequencer: RTL and testbench
================================

# mul_sequencer

Multi-cycle integer multiply controller for the execute stage. It accepts a MUL command with its two operands and runs an iterative shift-add multiplication, one multiplier bit per cycle, with early exit. While it works it holds the IF/ID/EX pipeline registers through a freeze output. It hands a single-cycle result, with writeback enable and N/Z flags, to the EXE/MEM register.

## Interface
- `WIDTH`, 32, operand and result width.
- `CNT_W`, 5, iteration counter width; $clog2(WIDTH).
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  the EX-stage instruction is a valid MUL; held high while frozen.
- `flush`  in  1  kill the in-flight multiply.
- `op_a`  in  WIDTH  multiplicand (val_Rn).
- `op_b`  in  WIDTH  multiplier (val_Rm).
- `s_bit`  in  1  update-status request.
- `dest_in`  in  4  destination register.
- `freeze`  out  1  stall IF/ID/EX registers.
- `done`  out  1  one-cycle result-valid pulse.
- `wb_en`  out  1  writeback enable; equals `done`.
- `result`  out  WIDTH  low WIDTH bits of op_a*op_b.
- `dest`  out  4  latched `dest_in`.
- `status_we`  out  1  `done & latched s_bit`.
- `n_flag`, `z_flag`  out  1 each  result[WIDTH-1] and (result==0); C and V are not produced.

## Operation
- States are IDLE, RUN and DONE.
- IDLE, `start=1`, `flush=0`:
  - latch a←op_a, b←op_b, acc←0, cnt←0, dest, s_bit;
  - go to RUN.
- RUN, one step per cycle:
  - if b[0], acc←acc+a (mod 2^WIDTH);
  - a←a<<1, b←b>>1, cnt←cnt+1.
- Exit RUN to DONE when cnt==WIDTH-1 or (b>>1)==0, evaluated on the pre-step values.
- DONE, for one cycle:
  - result=acc, done=1;
  - go to IDLE unconditionally;
  - `start` is ignored (it is still the same instruction).
- `flush`:
  - in IDLE or RUN: go to IDLE next cycle, no done, state registers cleared;
  - in DONE: suppresses done, wb_en and status_we that cycle.
- `freeze = (IDLE & start & ~flush) | RUN`. It is combinational and deasserts in DONE so the instruction advances with the result.
- Flags are computed combinationally from acc and are qualified only by done.

## Timing
- On reset, and while rst is high: state=IDLE, a/b/acc/cnt=0, dest=0.
  - All outputs read 0: freeze, done, wb_en, result, status_we, n_flag, z_flag.
- Reset mid-RUN aborts immediately; there is no done.
- Latency from the start cycle S:
  - RUN occupies cycles S+1 … S+k, with k = max(1, index of highest set bit of op_b + 1), so k=1 for op_b=0 and k=WIDTH for op_b[WIDTH-1]=1.
  - DONE is at S+k+1.
  - freeze is high for cycles S … S+k.
- Back-to-back MULs: the next start is accepted no earlier than S+k+2, after one IDLE cycle.
- result, dest and flags are stable through DONE. Outside DONE, result holds the current acc and dest holds its latched value; downstream logic must qualify both with done.

## Structure
- Package `exe_pkg`:
  - `mul_state_t` enum {IDLE, RUN, DONE};
  - `MUL_WIDTH` = 32;
  - NZCV bit-index constants shared with the ALU status path.
- Sub-module `mul_step_dp`: the a/b/acc registers and the adder/shifters, with load/step/clear controls. The FSM and counter live in `mul_sequencer`.

## Test plan
- Reset mid-RUN (op_b=0xFFFF, assert rst at S+3): all outputs 0 the same cycle; no done after release.
- op_a=7, op_b=5, s_bit=1: freeze high S…S+3; done at S+4 with result=35, wb_en=1, status_we=1, n=0, z=0.
- op_a=0x12345678, op_b=0: k=1; done at S+2 with result=0, z=1.
- op_a=0xFFFFFFFF, op_b=0x80000000: 32 RUN cycles; done at S+33 with result=0x80000000, n=1.
- flush at S+2 with op_b=0xFF: no done; freeze low from S+3; a new start at S+4 with 3×3 gives done at S+7 with result=9.
- `start` held high through DONE: exactly one done pulse, and no second multiply begins.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared execute-stage definitions.
// Contents:
//   mul_state_t         - multiply sequencer FSM states
//   MUL_WIDTH           - default operand/result width
//   FLAG_N..FLAG_V      - NZCV bit positions used by the status path
//   mul_zero_flag()     - zero-detect helper for the result flags
package exe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int MUL_WIDTH = 32;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Zero detect on a full-width result word.
    function automatic logic mul_zero_flag(input logic [MUL_WIDTH-1:0] value);
        return (value == {MUL_WIDTH{1'b0}});
    endfunction

endpackage

// File: rtl/mul_step_dp.sv
// Shift-add multiply datapath: multiplicand, multiplier and accumulator
// registers with one shift-add step per enabled cycle.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   clear        - zero all registers (highest priority)
//   load         - capture op_a/op_b, zero the accumulator
//   step         - one iteration: conditional add, shift a left, b right
//   op_a, op_b   - multiplicand / multiplier
//   acc          - running product (registered)
//   last_step    - remaining multiplier after this step is zero
module mul_step_dp
    import exe_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] acc,
    output logic             last_step
);

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;

    // Operand and accumulator registers; clear wins over load, load over step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= {WIDTH{1'b0}};
            b_r   <= {WIDTH{1'b0}};
            acc_r <= {WIDTH{1'b0}};
        end else if (clear) begin
            a_r   <= {WIDTH{1'b0}};
            b_r   <= {WIDTH{1'b0}};
            acc_r <= {WIDTH{1'b0}};
        end else if (load) begin
            a_r   <= op_a;
            b_r   <= op_b;
            acc_r <= {WIDTH{1'b0}};
        end else if (step) begin
            if (b_r[0]) begin
                acc_r <= acc_r + a_r;
            end
            a_r <= {a_r[WIDTH-2:0], 1'b0};
            b_r <= {1'b0, b_r[WIDTH-1:1]};
        end
    end

    assign acc       = acc_r;
    // Early exit: no set bits remain above the one consumed this cycle.
    assign last_step = (b_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle multiply controller for the execute stage. Runs a shift-add
// multiply one multiplier bit per cycle with early exit, freezes the front
// of the pipeline meanwhile, and presents a one-cycle result with flags.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   start                 - valid MUL in EX (held while frozen)
//   flush                 - kill the in-flight multiply
//   op_a, op_b            - multiplicand / multiplier
//   s_bit, dest_in        - status-update request, destination register
//   freeze                - stall IF/ID/EX registers
//   done, wb_en           - one-cycle result valid / writeback enable
//   result, dest          - product (low WIDTH bits), latched destination
//   status_we             - done qualified by the latched s_bit
//   n_flag, z_flag        - negative / zero flags, qualified by done
module mul_sequencer
    import exe_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             s_bit,
    input  logic [3:0]       dest_in,
    output logic             freeze,
    output logic             done,
    output logic             wb_en,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       dest,
    output logic             status_we,
    output logic             n_flag,
    output logic             z_flag
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mul_state_t       state_r;
    mul_state_t       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       dest_r;
    logic             s_bit_r;
    logic             load_s;
    logic             step_s;
    logic             clear_s;
    logic             last_step_s;
    logic [WIDTH-1:0] acc_s;
    logic             done_s;

    mul_step_dp #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_s),
        .load      (load_s),
        .step      (step_s),
        .op_a      (op_a),
        .op_b      (op_b),
        .acc       (acc_s),
        .last_step (last_step_s)
    );

    // FSM state, iteration counter and latched instruction fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            dest_r  <= 4'd0;
            s_bit_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (clear_s || load_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (step_s) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (load_s) begin
                dest_r  <= dest_in;
                s_bit_r <= s_bit;
            end
        end
    end

    // Next-state and datapath controls.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        clear_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (flush) begin
                    clear_s = 1'b1;
                end else if (start) begin
                    load_s      = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (flush) begin
                    clear_s     = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    step_s = 1'b1;
                    // Exit test uses pre-step values, so the final step still executes.
                    if ((cnt_r == CNT_LAST) || last_step_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
            end
            DONE: begin
                // start is still the same instruction here, so it is ignored.
                state_nxt_s = IDLE;
            end
            default: begin
                clear_s     = 1'b1;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Result-valid and freeze; freeze is gated by rst so outputs read 0 in reset.
    always_comb begin
        done_s = (state_r == DONE) && !flush;
        freeze = !rst && (((state_r == IDLE) && start && !flush) || (state_r == RUN));
    end

    assign done      = done_s;
    assign wb_en     = done_s;
    assign status_we = done_s & s_bit_r;
    assign result    = acc_s;
    assign dest      = dest_r;
    assign n_flag    = done_s & acc_s[WIDTH-1];
    assign z_flag    = done_s & mul_zero_flag(acc_s);

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed cases plus randomized
// multiplies compared against a plain-arithmetic reference model.
module tb_mul_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        s_bit;
    logic [3:0]  dest_in;
    logic        freeze;
    logic        done;
    logic        wb_en;
    logic [31:0] result;
    logic [3:0]  dest;
    logic        status_we;
    logic        n_flag;
    logic        z_flag;

    int n_cmp;
    int n_err;

    mul_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .flush     (flush),
        .op_a      (op_a),
        .op_b      (op_b),
        .s_bit     (s_bit),
        .dest_in   (dest_in),
        .freeze    (freeze),
        .done      (done),
        .wb_en     (wb_en),
        .result    (result),
        .dest      (dest),
        .status_we (status_we),
        .n_flag    (n_flag),
        .z_flag    (z_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_freeze"}, {31'd0, freeze}, 32'd0);
        check_val({tag, "_done"}, {31'd0, done}, 32'd0);
        check_val({tag, "_wb_en"}, {31'd0, wb_en}, 32'd0);
        check_val({tag, "_result"}, result, 32'd0);
        check_val({tag, "_dest"}, {28'd0, dest}, 32'd0);
        check_val({tag, "_status_we"}, {31'd0, status_we}, 32'd0);
        check_val({tag, "_n"}, {31'd0, n_flag}, 32'd0);
        check_val({tag, "_z"}, {31'd0, z_flag}, 32'd0);
    endtask

    // One MUL: start at cycle S, start held through DONE, optional flush in DONE.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [3:0] d, input bit flush_done);
        logic [63:0] prod;
        logic [31:0] exp_r;
        logic        exp_done;
        int          k;
        prod  = {32'd0, a} * {32'd0, b};
        exp_r = prod[31:0];
        k = 1;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) k = i + 1;
        end
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b0; op_a = a; op_b = b; s_bit = s; dest_in = d;
        @(negedge clk);
        check_val("freeze_start", {31'd0, freeze}, 32'd1);
        check_val("done_start", {31'd0, done}, 32'd0);
        for (int c = 1; c <= k; c++) begin
            @(posedge clk); #1;
            op_a = $urandom; op_b = $urandom; s_bit = ~s; dest_in = ~d;
            @(negedge clk);
            check_val("freeze_run", {31'd0, freeze}, 32'd1);
            check_val("done_run", {31'd0, done}, 32'd0);
        end
        @(posedge clk); #1;
        flush = flush_done;
        exp_done = !flush_done;
        @(negedge clk);
        check_val("done", {31'd0, done}, {31'd0, exp_done});
        check_val("wb_en", {31'd0, wb_en}, {31'd0, exp_done});
        check_val("status_we", {31'd0, status_we}, {31'd0, exp_done & s});
        check_val("result", result, exp_r);
        check_val("n_flag", {31'd0, n_flag}, {31'd0, exp_done & exp_r[31]});
        check_val("z_flag", {31'd0, z_flag}, {31'd0, exp_done & (exp_r == 32'd0)});
        check_val("freeze_done", {31'd0, freeze}, 32'd0);
        if (exp_done) check_val("dest", {28'd0, dest}, {28'd0, d});
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check_val("done_after", {31'd0, done}, 32'd0);
        check_val("freeze_after", {31'd0, freeze}, 32'd0);
    endtask

    initial begin
        int          saw_done;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sh;
        n_cmp = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        op_a = 32'd0; op_b = 32'd0; s_bit = 1'b0; dest_in = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1; rst = 1'b0;

        // Reset mid-RUN: start S, rst asserted at S+3.
        @(posedge clk); #1;
        start = 1'b1; op_a = 32'd3; op_b = 32'h0000_FFFF; s_bit = 1'b1; dest_in = 4'd9;
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_mid");
        @(posedge clk); #1; rst = 1'b0; start = 1'b0;
        saw_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        check_val("rst_no_done", saw_done, 32'd0);

        // Directed multiplies.
        run_mul(32'd7, 32'd5, 1'b1, 4'd3, 1'b0);
        run_mul(32'h1234_5678, 32'd0, 1'b1, 4'd5, 1'b0);
        run_mul(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 4'd12, 1'b0);

        // Flush at S+2 in RUN, then a fresh 3x3 starting at S+4.
        @(posedge clk); #1;
        start = 1'b1; op_a = 32'd11; op_b = 32'h0000_00FF; s_bit = 1'b1; dest_in = 4'd2;
        @(negedge clk);
        check_val("fl_freeze_s", {31'd0, freeze}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("fl_freeze_s1", {31'd0, freeze}, 32'd1);
        @(posedge clk); #1; flush = 1'b1;
        @(negedge clk);
        check_val("fl_done_s2", {31'd0, done}, 32'd0);
        @(posedge clk); #1; flush = 1'b0; start = 1'b0;
        @(negedge clk);
        check_val("fl_freeze_s3", {31'd0, freeze}, 32'd0);
        check_val("fl_done_s3", {31'd0, done}, 32'd0);
        run_mul(32'd3, 32'd3, 1'b0, 4'd7, 1'b0);

        // Flush during DONE suppresses the pulse.
        run_mul(32'd6, 32'd9, 1'b1, 4'd1, 1'b1);

        // Randomized multiplies with varying multiplier bit length.
        for (int t = 0; t < 40; t++) begin
            ra = $urandom;
            rb = $urandom;
            sh = $urandom_range(0, 32);
            rb = (sh == 32) ? 32'd0 : (rb >> sh);
            if ($urandom_range(0, 9) == 0) ra = 32'd0;
            run_mul(ra, rb, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
